// File: rtl/l2_dmem_bank_arb.sv
// Per-bank arbiter: one single-port SRAM shared by core/DMA read and write requesters.
// Read returns are buffered per port so a read is only granted when its result has a slot.
module l2_dmem_bank_arb #(
    parameter int ADDR_W       = 9,
    parameter int DATA_W       = 256,
    parameter int RD_BUF_DEPTH = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              core_rd_req,
    output logic              core_rd_gnt,
    input  logic [ADDR_W-1:0] core_rd_addr,
    output logic              core_rd_valid,
    output logic [DATA_W-1:0] core_rd_data,
    input  logic              core_rd_ready,

    input  logic              core_wr_req,
    output logic              core_wr_gnt,
    input  logic [ADDR_W-1:0] core_wr_addr,
    input  logic [DATA_W-1:0] core_wr_data,

    input  logic              dma_rd_req,
    output logic              dma_rd_gnt,
    input  logic [ADDR_W-1:0] dma_rd_addr,
    output logic              dma_rd_valid,
    output logic [DATA_W-1:0] dma_rd_data,
    input  logic              dma_rd_ready,

    input  logic              dma_wr_req,
    output logic              dma_wr_gnt,
    input  logic [ADDR_W-1:0] dma_wr_addr,
    input  logic [DATA_W-1:0] dma_wr_data,

    output logic              sram_cs,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int NREQ   = 4;
    localparam int NRD    = 2;
    localparam int CNT_W  = $clog2(RD_BUF_DEPTH + 1);
    localparam int PTR_W  = (RD_BUF_DEPTH > 1) ? $clog2(RD_BUF_DEPTH) : 1;
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   eligible;
    logic [NREQ-1:0]   starved;
    logic [NREQ-1:0]   gnt;
    logic [1:0]        winner;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [WAIT_W-1:0] wait_q [NREQ];
    logic [WAIT_W-1:0] wait_d [NREQ];

    logic [NRD-1:0]    inflight_q;
    logic [NRD-1:0]    push, pop, rd_valid, rd_ready;
    logic [CNT_W-1:0]  cnt_q    [NRD];
    logic [PTR_W-1:0]  wr_ptr_q [NRD];
    logic [PTR_W-1:0]  rd_ptr_q [NRD];
    logic [DATA_W-1:0] mem_q    [NRD][RD_BUF_DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RD_BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Requests are masked during reset so no grant or SRAM access can escape.
    assign req      = {dma_wr_req, dma_rd_req, core_wr_req, core_rd_req} & {NREQ{rst_n}};
    assign rd_ready = {dma_rd_ready, core_rd_ready};

    // Read credit: a slot is reserved by the grant and released only by a past pop.
    always_comb begin
        eligible = req;
        for (int r = 0; r < NRD; r++) begin
            if (inflight_q[r])
                eligible[2*r] = req[2*r] && (cnt_q[r] < CNT_W'(RD_BUF_DEPTH - 1));
            else
                eligible[2*r] = req[2*r] && (cnt_q[r] < CNT_W'(RD_BUF_DEPTH));
        end
        for (int i = 0; i < NREQ; i++)
            starved[i] = eligible[i] && (wait_q[i] == WAIT_W'(STARVE_LIMIT));
    end

    always_comb begin
        logic       found;
        logic [1:0] idx;
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && starved[i]) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            idx = rr_ptr_q + 2'(i);
            if (!found && eligible[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        winner = '0;
        for (int i = 0; i < NREQ; i++)
            if (gnt[i]) winner = 2'(i);
        rr_ptr_d = (|gnt) ? winner + 2'd1 : rr_ptr_q;
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            if (!req[i] || gnt[i])
                wait_d[i] = '0;
            else if (wait_q[i] != WAIT_W'(STARVE_LIMIT))
                wait_d[i] = wait_q[i] + WAIT_W'(1);
            else
                wait_d[i] = wait_q[i];
        end
    end

    always_comb begin
        sram_cs    = |gnt;
        sram_we    = gnt[1] | gnt[3];
        sram_addr  = '0;
        sram_wdata = '0;
        if (gnt[0]) sram_addr = core_rd_addr;
        if (gnt[1]) begin
            sram_addr  = core_wr_addr;
            sram_wdata = core_wr_data;
        end
        if (gnt[2]) sram_addr = dma_rd_addr;
        if (gnt[3]) begin
            sram_addr  = dma_wr_addr;
            sram_wdata = dma_wr_data;
        end
    end

    assign core_rd_gnt = gnt[0];
    assign core_wr_gnt = gnt[1];
    assign dma_rd_gnt  = gnt[2];
    assign dma_wr_gnt  = gnt[3];

    // Return handshake: head is presented while valid; a beat transfers on valid && ready,
    // and the head stays stable while valid is held without ready.
    always_comb begin
        for (int r = 0; r < NRD; r++) begin
            rd_valid[r] = (cnt_q[r] != '0);
            push[r]     = inflight_q[r];
            pop[r]      = rd_valid[r] && rd_ready[r];
        end
    end

    assign core_rd_valid = rd_valid[0];
    assign dma_rd_valid  = rd_valid[1];
    assign core_rd_data  = rd_valid[0] ? mem_q[0][rd_ptr_q[0]] : '0;
    assign dma_rd_data   = rd_valid[1] ? mem_q[1][rd_ptr_q[1]] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            inflight_q <= '0;
            for (int i = 0; i < NREQ; i++) wait_q[i] <= '0;
            for (int r = 0; r < NRD; r++) begin
                cnt_q[r]    <= '0;
                wr_ptr_q[r] <= '0;
                rd_ptr_q[r] <= '0;
            end
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            inflight_q <= {gnt[2], gnt[0]};
            for (int i = 0; i < NREQ; i++) wait_q[i] <= wait_d[i];
            for (int r = 0; r < NRD; r++) begin
                if (push[r]) wr_ptr_q[r] <= ptr_inc(wr_ptr_q[r]);
                if (pop[r])  rd_ptr_q[r] <= ptr_inc(rd_ptr_q[r]);
                case ({push[r], pop[r]})
                    2'b10:   cnt_q[r] <= cnt_q[r] + CNT_W'(1);
                    2'b01:   cnt_q[r] <= cnt_q[r] - CNT_W'(1);
                    default: cnt_q[r] <= cnt_q[r];
                endcase
            end
        end
    end

    // Storage needs no reset: entries are only visible through a nonzero count.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NRD; r++)
            if (push[r]) mem_q[r][wr_ptr_q[r]] <= sram_rdata;
    end

    for (genvar r = 0; r < NRD; r++) begin : g_ovf_chk
        a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
            !(push[r] && !pop[r] && (cnt_q[r] == CNT_W'(RD_BUF_DEPTH))));
    end

endmodule

// File: tb/tb_l2_dmem_bank_arb.sv
// Randomised and directed bench for l2_dmem_bank_arb with a cycle-level reference model,
// an SRAM behavioural model, and a scoreboard of expected read-return data.
module tb_l2_dmem_bank_arb;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 256;
    localparam int DEPTH  = 2;
    localparam int LIMIT  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              core_rd_req, core_rd_gnt, core_rd_valid, core_rd_ready;
    logic [ADDR_W-1:0] core_rd_addr;
    logic [DATA_W-1:0] core_rd_data;
    logic              core_wr_req, core_wr_gnt;
    logic [ADDR_W-1:0] core_wr_addr;
    logic [DATA_W-1:0] core_wr_data;
    logic              dma_rd_req, dma_rd_gnt, dma_rd_valid, dma_rd_ready;
    logic [ADDR_W-1:0] dma_rd_addr;
    logic [DATA_W-1:0] dma_rd_data;
    logic              dma_wr_req, dma_wr_gnt;
    logic [ADDR_W-1:0] dma_wr_addr;
    logic [DATA_W-1:0] dma_wr_data;
    logic              sram_cs, sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    l2_dmem_bank_arb #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_BUF_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .core_rd_req(core_rd_req), .core_rd_gnt(core_rd_gnt), .core_rd_addr(core_rd_addr),
        .core_rd_valid(core_rd_valid), .core_rd_data(core_rd_data), .core_rd_ready(core_rd_ready),
        .core_wr_req(core_wr_req), .core_wr_gnt(core_wr_gnt), .core_wr_addr(core_wr_addr),
        .core_wr_data(core_wr_data),
        .dma_rd_req(dma_rd_req), .dma_rd_gnt(dma_rd_gnt), .dma_rd_addr(dma_rd_addr),
        .dma_rd_valid(dma_rd_valid), .dma_rd_data(dma_rd_data), .dma_rd_ready(dma_rd_ready),
        .dma_wr_req(dma_wr_req), .dma_wr_gnt(dma_wr_gnt), .dma_wr_addr(dma_wr_addr),
        .dma_wr_data(dma_wr_data),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // SRAM behavioural model: read data appears the cycle after the access
    logic [DATA_W-1:0] sram_mem [1 << ADDR_W];
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we) sram_mem[sram_addr] <= sram_wdata;
            else         sram_rdata <= sram_mem[sram_addr];
        end
    end

    // Scoreboard state
    int                n_checks = 0;
    int                n_fail   = 0;
    logic [DATA_W-1:0] exp_q [2][$];

    function automatic void check(string nm, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference model: grant rules evaluated per cycle on plain integers and queues.
    logic [DATA_W-1:0] ref_mem [1 << ADDR_W];
    int                cyc = 0;
    int                m_rr = 0;
    int                m_wait [4];
    int                m_out  [2][$];

    always @(negedge clk) begin
        logic [3:0]        r, g, elig, exp_g;
        logic [1:0]        rv, rdy;
        logic [ADDR_W-1:0] a_exp;
        int                win, q;
        logic              ev;
        cyc++;
        r   = {dma_wr_req, dma_rd_req, core_wr_req, core_rd_req};
        g   = {dma_wr_gnt, dma_rd_gnt, core_wr_gnt, core_rd_gnt};
        rv  = {dma_rd_valid, core_rd_valid};
        rdy = {dma_rd_ready, core_rd_ready};
        if (!rst_n) begin
            check("rst_gnt", DATA_W'(g), '0);
            check("rst_sram_cs_we", DATA_W'({sram_cs, sram_we}), '0);
            check("rst_valid", DATA_W'(rv), '0);
            check("rst_rd_data", core_rd_data | dma_rd_data, '0);
            m_rr = 0;
            for (int p = 0; p < 4; p++) m_wait[p] = 0;
            for (int k = 0; k < 2; k++) begin
                m_out[k].delete();
                exp_q[k].delete();
            end
        end else begin
            elig = r;
            if (m_out[0].size() >= DEPTH) elig[0] = 1'b0;
            if (m_out[1].size() >= DEPTH) elig[2] = 1'b0;
            win = -1;
            for (int p = 0; p < 4; p++)
                if (win < 0 && elig[p] && m_wait[p] == LIMIT) win = p;
            for (int i = 0; i < 4; i++) begin
                q = (m_rr + i) % 4;
                if (win < 0 && elig[q]) win = q;
            end
            exp_g = '0;
            if (win >= 0) exp_g[win] = 1'b1;
            case (win)
                0:       a_exp = core_rd_addr;
                1:       a_exp = core_wr_addr;
                2:       a_exp = dma_rd_addr;
                3:       a_exp = dma_wr_addr;
                default: a_exp = '0;
            endcase
            check("gnt", DATA_W'(g), DATA_W'(exp_g));
            check("sram_cs", DATA_W'(sram_cs), DATA_W'(win >= 0));
            check("sram_we", DATA_W'(sram_we), DATA_W'(win == 1 || win == 3));
            check("sram_addr", DATA_W'(sram_addr), DATA_W'(a_exp));
            if (win == 1) check("sram_wdata", sram_wdata, core_wr_data);
            if (win == 3) check("sram_wdata", sram_wdata, dma_wr_data);
            for (int k = 0; k < 2; k++) begin
                ev = (m_out[k].size() > 0) && (m_out[k][0] <= cyc - 2);
                check(k == 0 ? "core_rd_valid" : "dma_rd_valid", DATA_W'(rv[k]), DATA_W'(ev));
                if (ev && rdy[k]) void'(m_out[k].pop_front());
            end
            if (win >= 0) begin
                m_rr = (win + 1) % 4;
                if (win == 1) ref_mem[core_wr_addr] = core_wr_data;
                if (win == 3) ref_mem[dma_wr_addr]  = dma_wr_data;
                if (win == 0 || win == 2) begin
                    m_out[win / 2].push_back(cyc);
                    exp_q[win / 2].push_back(ref_mem[a_exp]);
                end
            end
            for (int p = 0; p < 4; p++) begin
                if (!r[p] || p == win) m_wait[p] = 0;
                else if (m_wait[p] < LIMIT) m_wait[p] = m_wait[p] + 1;
            end
        end
    end

    // Monitor: compares returned data against the expected queue on each transfer
    always @(negedge clk) begin
        if (rst_n) begin
            if (core_rd_valid && core_rd_ready) begin
                if (exp_q[0].size() == 0) check("core_rd_unexpected", DATA_W'(1), '0);
                else check("core_rd_data", core_rd_data, exp_q[0].pop_front());
            end
            if (dma_rd_valid && dma_rd_ready) begin
                if (exp_q[1].size() == 0) check("dma_rd_unexpected", DATA_W'(1), '0);
                else check("dma_rd_data", dma_rd_data, exp_q[1].pop_front());
            end
        end
    end

    // Driver tasks
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        core_rd_req = 1'b0; core_wr_req = 1'b0; dma_rd_req = 1'b0; dma_wr_req = 1'b0;
        core_rd_ready = 1'b1; dma_rd_ready = 1'b1;
    endtask

    task automatic rand_addrs(input int span);
        core_rd_addr = ADDR_W'($urandom_range(span - 1, 0));
        core_wr_addr = ADDR_W'($urandom_range(span - 1, 0));
        dma_rd_addr  = ADDR_W'($urandom_range(span - 1, 0));
        dma_wr_addr  = ADDR_W'($urandom_range(span - 1, 0));
        core_wr_data = rand_word();
        dma_wr_data  = rand_word();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [DATA_W-1:0] v;
        rst_n = 1'b0;
        idle();
        rand_addrs(16);
        sram_rdata = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            v = rand_word();
            if (i == 5) v = {(DATA_W / 8){8'hA5}};
            sram_mem[i] = v;
            ref_mem[i]  = v;
        end
        cycles(3);
        rst_n = 1'b1;

        // Single core read of preloaded address
        core_rd_req = 1'b1; core_rd_addr = 9'h005;
        cycles(1);
        idle();
        cycles(4);

        // All four requesters continuously from reset
        do_reset();
        core_rd_req = 1'b1; core_wr_req = 1'b1; dma_rd_req = 1'b1; dma_wr_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rand_addrs(16);
            cycles(1);
        end
        idle();
        cycles(4);

        // DMA read backpressure fills its buffer, then drains in order
        dma_rd_ready = 1'b0; dma_rd_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_addrs(16);
            cycles(1);
        end
        dma_rd_ready = 1'b1;
        cycles(6);
        idle();
        cycles(4);

        // Starvation: core read blocked by a full buffer while others compete
        core_rd_ready = 1'b0;
        core_rd_req = 1'b1; core_wr_req = 1'b1; dma_rd_req = 1'b1; dma_wr_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_addrs(16);
            cycles(1);
        end
        core_rd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_addrs(16);
            cycles(1);
        end
        idle();
        cycles(4);

        // Write then read of the same address
        core_wr_req = 1'b1; core_wr_addr = 9'h010; core_wr_data = DATA_W'(32'h1234);
        cycles(1);
        core_wr_req = 1'b0; core_rd_req = 1'b1; core_rd_addr = 9'h010;
        cycles(1);
        idle();
        cycles(4);

        // Reset one cycle after a read grant discards the read
        core_rd_req = 1'b1; core_rd_addr = 9'h003;
        cycles(1);
        core_rd_req = 1'b0;
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        core_wr_req = 1'b1; dma_rd_req = 1'b1; dma_wr_req = 1'b1;
        cycles(1);
        idle();
        cycles(5);

        // Random traffic with one mid-stream reset
        for (int i = 0; i < 400; i++) begin
            rand_addrs(32);
            core_rd_req   = ($urandom_range(99, 0) < 60);
            core_wr_req   = ($urandom_range(99, 0) < 50);
            dma_rd_req    = ($urandom_range(99, 0) < 60);
            dma_wr_req    = ($urandom_range(99, 0) < 50);
            core_rd_ready = ($urandom_range(99, 0) < 70);
            dma_rd_ready  = ($urandom_range(99, 0) < 70);
            if (i == 200) rst_n = 1'b0;
            if (i == 202) rst_n = 1'b1;
            cycles(1);
        end
        rst_n = 1'b1;
        idle();
        cycles(10);

        check("core_exp_q_drained", DATA_W'(exp_q[0].size()), '0);
        check("dma_exp_q_drained", DATA_W'(exp_q[1].size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
